crp16_scoreboard_register_file: RTL
===================================

// Module: crp16_scoreboard_register_file
// PURPOSE
//  Parametrised general-purpose register file for the pipelined CRP16 core: two
//  combinational read ports, one synchronous write port, and a per-register busy
//  scoreboard. Decode marks a destination busy at issue; writeback writes it and
//  clears the mark. Decode stalls on a not-ready operand. Optional write-to-read
//  bypass. Register 0 optionally reads as constant zero and is read-only.
// PARAMETERS
//  DATA_WIDTH  16  width of each register and each data port
//  ADDR_WIDTH  4   select width; NUM_REGS = 2**ADDR_WIDTH
//  BYPASS      1   1: a read that matches the same-cycle write returns load_val; 0: no forwarding
//  ZERO_REG    1   1: register 0 always reads 0 (writes/reserves ignored); 0: register 0 is ordinary
// PORTS
//  clock          in   1           rising-edge clock
//  resetn         in   1           synchronous, active-low reset
//  reg_a_select   in   ADDR_WIDTH  read port A address
//  reg_b_select   in   ADDR_WIDTH  read port B address
//  reg_a_val      out  DATA_WIDTH  read port A data (combinational)
//  reg_b_val      out  DATA_WIDTH  read port B data (combinational)
//  reg_a_ready    out  1           1 when port A data is valid (register not busy, or bypass hit)
//  reg_b_ready    out  1           1 when port B data is valid
//  load_val       in   DATA_WIDTH  write data
//  write_select   in   ADDR_WIDTH  write address
//  write          in   1           write enable
//  reserve        in   1           marks reserve_select busy at the next edge
//  reserve_select in   ADDR_WIDTH  register to mark busy
//  busy_vec       out  NUM_REGS    registered busy bits; bit i = register i
// BEHAVIOUR
//  - Reset: one clock and resetn are already decided. Reset is synchronous and
//    active-low. At a rising edge with resetn=0, all registers go to 0 and
//    busy_vec goes to 0. Reset overrides write and reserve in the same cycle.
//    After reset, every read returns 0 with ready=1.
//  - Reads: zero latency and purely combinational from the selects, the storage
//    and the busy bits. Ports A and B are fully independent and may share an address.
//  - Bypass (BYPASS=1): the port hits when write=1, write_select == port select,
//    and the address is not the zero register. On a hit, val = load_val and
//    ready = 1, regardless of the busy bit.
//  - Without a bypass hit: val = stored value; ready = ~busy[select].
//  - Write: at the rising edge with resetn=1 and write=1:
//      reg[write_select] <= load_val; busy[write_select] <= 0.
//    Writing a register that is not busy is legal: data updates, busy stays 0.
//  - Reserve: at the rising edge with resetn=1 and reserve=1:
//      busy[reserve_select] <= 1.
//    Reserving an already-busy register is legal; it stays 1 (no counting).
//  - Write and reserve to the same address in one cycle: data is written and
//    busy ends at 1. A new producer issues as the old one retires.
//  - Write and reserve to different addresses: both take effect independently.
//  - ZERO_REG=1, address 0:
//      val = 0 and ready = 1 always; no bypass.
//      Write and reserve are ignored; busy_vec[0] is constant 0.
//  - ZERO_REG=0: register 0 behaves like every other register.
//  - Select values are always in range (2**ADDR_WIDTH entries), so there is no
//    out-of-range case.
//  - Storage is flops, not RAM; there are no X outputs after the first reset edge.
// TESTING (defaults DATA_WIDTH=16, ADDR_WIDTH=4, BYPASS=1, ZERO_REG=1)
//  1. Hold resetn=0 for 2 edges with write=1 (sel 5, 16'hFFFF) -> all reads 0,
//     ready=1, busy_vec=0. Then write r5=16'h1234 -> next cycle A=r5 reads 16'h1234.
//  2. reserve r3 -> busy_vec=16'h0008, A=r3 ready=0. Next cycle write r3=16'hBEEF
//     with A=r3: same cycle A=16'hBEEF, ready=1 (bypass). After the edge busy_vec=0.
//  3. Same cycle: write r7=16'h00AA and reserve r7 -> after the edge r7=16'h00AA,
//     busy_vec[7]=1, reg_b_ready=0 for B=r7.
//  4. Write r0=16'h5555 and reserve r0 -> A=r0 reads 0, ready=1, busy_vec[0]=0.
//     Repeat with ZERO_REG=0 -> r0 reads 16'h5555 and busy_vec[0]=1.
//  5. BYPASS=0: reserve r9, then write r9=16'h0F0F with B=r9 -> same cycle B=old
//     value, ready=0. Next cycle B=16'h0F0F, ready=1.
//  6. Reserve r2 and r4, pulse resetn=0 for one edge mid-operation -> busy_vec=0
//     and r2=r4=0. A concurrent write of r2=16'h7777 is discarded.

Source files
------------

// File: rtl/crp16_scoreboard_register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : crp16_scoreboard_register_file_if
// Description : Bundle of the CRP16 register-file read, write and scoreboard
//               signals. The decode/writeback side uses the master modport and
//               the register file uses the slave modport.
// Signals     : reg_a_select / reg_b_select  read addresses (master -> slave)
//               reg_a_val / reg_b_val        read data      (slave -> master)
//               reg_a_ready / reg_b_ready    operand valid  (slave -> master)
//               load_val / write_select / write   write port (master -> slave)
//               reserve / reserve_select     busy-mark port (master -> slave)
//               busy_vec                     busy bits      (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface crp16_scoreboard_register_file_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] reg_a_select;
  logic [ADDR_WIDTH-1:0] reg_b_select;
  logic [DATA_WIDTH-1:0] reg_a_val;
  logic [DATA_WIDTH-1:0] reg_b_val;
  logic                  reg_a_ready;
  logic                  reg_b_ready;
  logic [DATA_WIDTH-1:0] load_val;
  logic [ADDR_WIDTH-1:0] write_select;
  logic                  write;
  logic                  reserve;
  logic [ADDR_WIDTH-1:0] reserve_select;
  logic [NUM_REGS-1:0]   busy_vec;

  modport master (
    output reg_a_select, reg_b_select, load_val, write_select, write,
           reserve, reserve_select,
    input  reg_a_val, reg_b_val, reg_a_ready, reg_b_ready, busy_vec
  );

  modport slave (
    input  reg_a_select, reg_b_select, load_val, write_select, write,
           reserve, reserve_select,
    output reg_a_val, reg_b_val, reg_a_ready, reg_b_ready, busy_vec
  );
endinterface
`default_nettype wire

// File: rtl/crp16_scoreboard_register_file.sv
`default_nettype none
// ============================================================================
// Module      : crp16_scoreboard_register_file
// Description : CRP16 general-purpose register file. Two combinational read
//               ports, one synchronous write port and a per-register busy
//               scoreboard. Decode reserves a destination at issue, writeback
//               writes it and releases the reservation. Optional write-to-read
//               bypass and optional hard-wired zero register.
// Ports       : clock   rising-edge clock
//               resetn  synchronous active-low reset
//               rf      register-file bundle (slave modport): read selects,
//                       read data/ready, write port, reserve port, busy_vec
// Parameters  : DATA_WIDTH register width, ADDR_WIDTH select width,
//               BYPASS 1 = forward same-cycle write data to reads,
//               ZERO_REG 1 = register 0 reads zero and ignores write/reserve
// Revision    : 1.0 - initial release
// ============================================================================
module crp16_scoreboard_register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  wire logic                          clock,
  input  wire logic                          resetn,
  crp16_scoreboard_register_file_if.slave    rf
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int NUM_PORTS = 2;

  // --------------------------------------------------------------------------
  // Storage and scoreboard
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;
  logic [NUM_REGS-1:0]   w_busy_next;

  // Register 0 is hard-wired only when ZERO_REG is set; the write and reserve
  // ports are gated here so the zero register's flops never change after reset.
  logic w_write_is_zero;
  logic w_reserve_is_zero;
  logic w_write_en;
  logic w_reserve_en;

  assign w_write_is_zero   = (ZERO_REG != 0) && (rf.write_select == '0);
  assign w_reserve_is_zero = (ZERO_REG != 0) && (rf.reserve_select == '0);
  assign w_write_en        = rf.write && !w_write_is_zero;
  assign w_reserve_en      = rf.reserve && !w_reserve_is_zero;

  // Release first, then mark: a retiring producer and a newly issued producer
  // on the same register leave it busy for the new producer.
  always_comb begin
    w_busy_next = r_busy;
    if (w_write_en) begin
      w_busy_next[rf.write_select] = 1'b0;
    end
    if (w_reserve_en) begin
      w_busy_next[rf.reserve_select] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_write_en) begin
        r_regs[rf.write_select] <= rf.load_val;
      end
      r_busy <= w_busy_next;
    end
  end

  assign rf.busy_vec = r_busy;

  // --------------------------------------------------------------------------
  // Read ports (identical, independent, purely combinational)
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_sel [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_val [NUM_PORTS];
  logic                  w_rdy [NUM_PORTS];

  assign w_sel[0] = rf.reg_a_select;
  assign w_sel[1] = rf.reg_b_select;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_read_port
    logic w_is_zero;
    logic w_hit;

    assign w_is_zero = (ZERO_REG != 0) && (w_sel[p] == '0);
    // Forwarding makes the writeback result visible in its own cycle, so a
    // stalled consumer can issue alongside the retiring producer.
    assign w_hit     = (BYPASS != 0) && rf.write &&
                       (rf.write_select == w_sel[p]) && !w_is_zero;

    assign w_val[p] = w_is_zero ? '0          :
                      w_hit     ? rf.load_val :
                                  r_regs[w_sel[p]];
    assign w_rdy[p] = w_is_zero | w_hit | ~r_busy[w_sel[p]];
  end

  assign rf.reg_a_val   = w_val[0];
  assign rf.reg_a_ready = w_rdy[0];
  assign rf.reg_b_val   = w_val[1];
  assign rf.reg_b_ready = w_rdy[1];

endmodule
`default_nettype wire
